// File: rtl/vend_session_arbiter.sv
// Shares one soda-vending datapath between two coin panels: one owner per session,
// nickel-unit credit, one-cycle vend/refund pulse, coin bounce for the non-owner.
module vend_session_arbiter #(
   parameter int PRICE   = 4,
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] nickle,
   input  logic [1:0] dime,
   input  logic [1:0] quarter,
   input  logic [1:0] cancel,
   output logic [1:0] grant,
   output logic       soda,
   output logic [2:0] change,
   output logic       served,
   output logic [1:0] reject,
   output logic       busy,
   output logic [1:0] dbg_state
);

   // Coin/cancel inputs and soda/change/reject outputs are single-cycle pulses with no
   // back-pressure: a pulse is consumed on the clock edge that samples it, outputs appear
   // one cycle later and are never held.
   typedef enum logic [1:0] {IDLE = 2'd0, SESSION = 2'd1, DISPENSE = 2'd2} state_t;

   localparam logic [3:0]    PRICE4 = 4'(PRICE);
   localparam logic [TW-1:0] TLAST  = TW'(TIMEOUT - 1);

   state_t        state, state_n;
   logic          owner, owner_n;
   logic [3:0]    credit, credit_n;
   logic [TW-1:0] timer, timer_n;
   logic          soda_n, served_n, busy_n;
   logic [2:0]    change_n;
   logic [1:0]    reject_n, grant_n;

   logic [1:0] coin_any, coin_ok;
   logic [3:0] val0, val1, own_val, sum;
   logic       pick;

   function automatic logic [3:0] coin_value(input logic n, input logic d, input logic q);
      return q ? 4'd5 : (d ? 4'd2 : (n ? 4'd1 : 4'd0));
   endfunction

   assign coin_any  = nickle | dime | quarter;
   assign coin_ok   = {$onehot({nickle[1], dime[1], quarter[1]}),
                       $onehot({nickle[0], dime[0], quarter[0]})};
   assign val0      = coin_value(nickle[0], dime[0], quarter[0]);
   assign val1      = coin_value(nickle[1], dime[1], quarter[1]);
   assign own_val   = owner ? val1 : val0;
   assign dbg_state = state;

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      credit_n = credit;
      timer_n  = timer;
      soda_n   = 1'b0;
      change_n = 3'd0;
      served_n = served;
      reject_n = 2'b00;
      pick     = 1'b0;
      sum      = 4'd0;
      case (state)
         IDLE: begin
            credit_n = 4'd0;
            timer_n  = '0;
            reject_n = coin_any & ~coin_ok;
            if (coin_ok != 2'b00) begin
               // On a tie the panel that was not served last gets the machine.
               if (coin_ok == 2'b11) begin
                  pick             = ~served;
                  reject_n[served] = 1'b1;
               end else begin
                  pick = coin_ok[1];
               end
               owner_n = pick;
               sum     = pick ? val1 : val0;
               if (sum >= PRICE4) begin
                  state_n  = DISPENSE;
                  soda_n   = 1'b1;
                  change_n = 3'(sum - PRICE4);
                  served_n = pick;
               end else begin
                  state_n  = SESSION;
                  credit_n = sum;
               end
            end
         end
         SESSION: begin
            reject_n[~owner] = coin_any[~owner];
            reject_n[owner]  = coin_any[owner] & ~coin_ok[owner];
            sum = credit + (coin_ok[owner] ? own_val : 4'd0);
            // Coin is folded in before cancel is looked at, so a reaching coin vends.
            if (coin_ok[owner] && (sum >= PRICE4)) begin
               state_n  = DISPENSE;
               soda_n   = 1'b1;
               change_n = 3'(sum - PRICE4);
            end else if (cancel[owner]) begin
               state_n  = DISPENSE;
               change_n = sum[2:0];
            end else if (coin_ok[owner]) begin
               credit_n = sum;
               timer_n  = '0;
            end else if (timer == TLAST) begin
               state_n  = DISPENSE;
               change_n = credit[2:0];
            end else begin
               timer_n = timer + 1'b1;
            end
            if (state_n == DISPENSE) begin
               served_n = owner;
               credit_n = 4'd0;
               timer_n  = '0;
            end
         end
         DISPENSE: begin
            reject_n = coin_any;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n  = (state_n != IDLE);
      grant_n = busy_n ? (owner_n ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= 1'b0;
         credit <= 4'd0;
         timer  <= '0;
         grant  <= 2'b00;
         soda   <= 1'b0;
         change <= 3'd0;
         served <= 1'b1;
         reject <= 2'b00;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         owner  <= owner_n;
         credit <= credit_n;
         timer  <= timer_n;
         grant  <= grant_n;
         soda   <= soda_n;
         change <= change_n;
         served <= served_n;
         reject <= reject_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_vend_session_arbiter.sv
// Directed bench for vend_session_arbiter: the driver pushes expected dispense/reject
// events (with their cycle) into queues, a negedge monitor pops and compares them.
module tb_vend_session_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] nickle = 2'b00, dime = 2'b00, quarter = 2'b00, cancel = 2'b00;
   logic [1:0] grant, reject, dbg_state;
   logic       soda, served, busy;
   logic [2:0] change;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // dispense entry: {cycle[15:0], soda, change[2:0], served}; reject entry: {cycle[15:0], reject[1:0]}
   logic [20:0] exp_q[$];
   logic [17:0] rej_q[$];

   vend_session_arbiter #(.PRICE(4), .TIMEOUT(16), .TW(5)) dut (
      .clk(clk), .rst(rst), .nickle(nickle), .dime(dime), .quarter(quarter),
      .cancel(cancel), .grant(grant), .soda(soda), .change(change), .served(served),
      .reject(reject), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic step(input logic [1:0] n, input logic [1:0] d, input logic [1:0] q,
                       input logic [1:0] c);
      nickle = n; dime = d; quarter = q; cancel = c;
      @(posedge clk);
      #1;
      nickle = 2'b00; dime = 2'b00; quarter = 2'b00; cancel = 2'b00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00, 2'b00);
   endtask

   task automatic exp_disp_at(input int at, input logic s, input logic [2:0] ch, input logic sv);
      exp_q.push_back({16'(at), s, ch, sv});
   endtask

   task automatic exp_disp(input logic s, input logic [2:0] ch, input logic sv);
      exp_disp_at(cyc + 1, s, ch, sv);
   endtask

   task automatic exp_rej(input logic [1:0] r);
      rej_q.push_back({16'(cyc + 1), r});
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (soda || (change != 3'd0)) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected dispense: soda=%0b change=%0d served=%0b cycle=%0d",
                     soda, change, served, cyc);
         end else begin
            check("dispense {cycle,soda,change,served}", 32'({16'(cyc), soda, change, served}),
                  32'(exp_q.pop_front()));
         end
      end
      if (reject != 2'b00) begin
         if (rej_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected reject: reject=%b cycle=%0d", reject, cyc);
         end else begin
            check("reject {cycle,reject}", 32'({16'(cyc), reject}), 32'(rej_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset grant", 32'(grant), 32'(0));
      check("reset busy", 32'(busy), 32'(0));
      check("reset served", 32'(served), 32'(1));
      check("reset change", 32'(change), 32'(0));
      rst = 1'b0;

      // panel 0: dime, dime -> exact vend; coin during dispense bounces
      step(2'b00, 2'b01, 2'b00, 2'b00);
      check("s1 grant after open", 32'(grant), 32'(2'b01));
      check("s1 busy after open", 32'(busy), 32'(1));
      exp_disp(1'b1, 3'd0, 1'b0);
      step(2'b00, 2'b01, 2'b00, 2'b00);
      check("s1 grant in dispense", 32'(grant), 32'(2'b01));
      exp_rej(2'b10);
      step(2'b10, 2'b00, 2'b00, 2'b00);
      check("s1 grant after dispense", 32'(grant), 32'(0));
      check("s1 busy after dispense", 32'(busy), 32'(0));

      // panel 0: dime, foreign nickel bounced, quarter -> change 3
      step(2'b00, 2'b01, 2'b00, 2'b00);
      exp_rej(2'b10);
      step(2'b10, 2'b00, 2'b00, 2'b00);
      exp_disp(1'b1, 3'd3, 1'b0);
      step(2'b00, 2'b00, 2'b01, 2'b00);
      idle(1);

      // panel 1: nickel then cancel -> refund 1
      step(2'b10, 2'b00, 2'b00, 2'b00);
      check("s3 grant panel1", 32'(grant), 32'(2'b10));
      exp_disp(1'b0, 3'd1, 1'b1);
      step(2'b00, 2'b00, 2'b00, 2'b10);
      idle(1);
      step(2'b00, 2'b00, 2'b00, 2'b01);
      check("s3 cancel in idle ignored", 32'(busy), 32'(0));

      // tie after panel 1 was served: panel 0 wins, panel 1 bounced
      exp_rej(2'b10);
      step(2'b11, 2'b00, 2'b00, 2'b00);
      check("s3 tie winner", 32'(grant), 32'(2'b01));
      exp_disp(1'b0, 3'd1, 1'b0);
      step(2'b00, 2'b00, 2'b00, 2'b01);
      idle(1);

      // timeout: refund 17 cycles after the last coin
      exp_disp_at(cyc + 17, 1'b0, 3'd1, 1'b0);
      step(2'b01, 2'b00, 2'b00, 2'b00);
      idle(17);

      // a coin on cycle 15 restarts the idle count
      step(2'b01, 2'b00, 2'b00, 2'b00);
      idle(14);
      exp_disp_at(cyc + 17, 1'b0, 3'd2, 1'b0);
      step(2'b01, 2'b00, 2'b00, 2'b00);
      idle(17);

      // invalid double coin in idle
      exp_rej(2'b01);
      step(2'b01, 2'b01, 2'b00, 2'b00);
      check("edge invalid stays idle grant", 32'(grant), 32'(0));
      check("edge invalid stays idle busy", 32'(busy), 32'(0));

      // dime, then dime together with cancel -> vend wins
      step(2'b00, 2'b01, 2'b00, 2'b00);
      exp_disp(1'b1, 3'd0, 1'b0);
      step(2'b00, 2'b01, 2'b00, 2'b01);
      idle(1);

      // reset mid-session with credit 3 discards it silently
      step(2'b01, 2'b00, 2'b00, 2'b00);
      step(2'b00, 2'b01, 2'b00, 2'b00);
      check("rst pre busy", 32'(busy), 32'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst grant", 32'(grant), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst soda", 32'(soda), 32'(0));
      check("rst change", 32'(change), 32'(0));
      check("rst served", 32'(served), 32'(1));
      idle(20);
      check("rst no session", 32'(grant), 32'(0));

      idle(2);
      check("dispense queue drained", 32'(exp_q.size()), 32'(0));
      check("reject queue drained", 32'(rej_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vend_session_arbiter.md
# vend_session_arbiter

Front-end controller that shares one soda-vending datapath between two customer coin panels. It grants the machine to one panel per purchase session, accumulates that panel's coins as credit in nickel units, and issues a one-cycle soda/change dispense when credit reaches the price. It refunds credit on cancel or inactivity timeout and bounces coins from the non-granted panel. It sits between the two physical coin acceptors and the soda/change actuators.

## Interface
- PRICE, 4, soda price in nickel units (legal 1..7; 4 = 20 cents)
- TIMEOUT, 16, idle cycles in a session before automatic refund (legal 2..2^TW-1)
- TW, 5, width of the inactivity timer
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- nickle  in  2  per-panel nickel pulse, bit i = panel i, one cycle per coin
- dime  in  2  per-panel dime pulse
- quarter  in  2  per-panel quarter pulse
- cancel  in  2  per-panel cancel request, one-cycle pulse
- grant  out  2  one-hot owner of the current session; 0 when idle
- soda  out  1  one-cycle soda release pulse
- change  out  3  change/refund amount in nickels; valid only in the dispense cycle, else 0
- served  out  1  panel index of the current or last dispense
- reject  out  2  one-cycle coin-return pulse per panel
- busy  out  1  high while a session or dispense is in progress

## Operation
- Coin value per panel: nickel = 1, dime = 2, quarter = 5. A panel is valid in a cycle when exactly one of its three coin bits is high. A panel with two or more coin bits high is invalid: assert reject for that panel, add no credit.
- State IDLE: grant = 0, credit = 0, timer = 0.
  - First valid coin from panel p: enter SESSION, grant = one-hot p, credit = coin value, timer = 0.
  - Both panels valid in the same cycle: the panel that is not `served` wins. The loser gets reject.
  - cancel in IDLE is ignored.
- State SESSION, owner p:
  - A valid coin from p adds to credit and clears the timer. Credit is 4 bits and cannot overflow: max is PRICE-1+5 = 11.
  - Any coin from the other panel: reject for that panel, no credit change.
  - cancel from p: enter DISPENSE with soda = 0, change = credit (refund).
  - cancel from the other panel is ignored.
  - If credit + coin ≥ PRICE: enter DISPENSE with soda = 1, change = credit + coin − PRICE. The result is at most 4 and fits in 3 bits.
  - A coin and a cancel from p in the same cycle: the coin is added first, then the cancel is evaluated. If the price is reached, the vend wins; otherwise the full credit including the coin is refunded.
  - No valid coin for TIMEOUT consecutive cycles: enter DISPENSE as a refund, soda = 0, change = credit.
- State DISPENSE, lasts exactly one cycle:
  - soda and change are driven from registers.
  - served = p; grant stays p; busy = 1.
  - Coins from either panel in this cycle are rejected.
  - Next cycle: IDLE.
- Reset values: state IDLE, grant 0, soda 0, change 0, reject 0, busy 0, served 1, credit 0, timer 0. served = 1 makes panel 0 win the first tie.
- rst mid-session discards all credit with no refund pulse. The loss of coins on reset is accepted by design.

## Timing
- All outputs are registered.
- reject goes high the cycle after the offending coin and lasts one cycle.
- grant and busy go high the cycle after the session-opening coin.
- soda and change are valid the cycle after the coin that reaches the price, or after the cancel. They last exactly one cycle; change = 0 outside that cycle.
- The timer increments every SESSION cycle without a valid owner coin. When the timer equals TIMEOUT−1 in a cycle with no coin, DISPENSE follows on the next cycle. Refund therefore appears TIMEOUT+1 cycles after the last coin.
- Minimum spacing between dispenses is 2 cycles (DISPENSE, IDLE); a new session can open on the IDLE cycle.

## Test plan
- Panel 0: dime, dime (PRICE = 4). Expect soda = 1, change = 0, served = 0 for one cycle, exactly one cycle after the second dime; then grant = 0.
- Panel 0: dime, then quarter. Expect soda = 1, change = 3. Insert a panel-1 nickel mid-session: expect reject = 2'b10 and no credit change.
- Panel 1: nickel, then cancel. Expect soda = 0, change = 1, served = 1. Then send simultaneous first coins from both panels: panel 0 wins, reject = 2'b10.
- Panel 0: nickel, then 16 idle cycles (TIMEOUT = 16). Expect soda = 0, change = 1 on the 17th cycle after the nickel; a coin on cycle 15 restarts the count.
- Edge cases:
  - nickle and dime asserted together on panel 0 in IDLE: expect reject = 2'b01 and the machine stays idle.
  - Panel 0 dime, then dime together with cancel: expect a vend (soda = 1, change = 0).
- rst asserted during a session with credit 3: next cycle all outputs are 0, served = 1, and there is no dispense pulse.
